// File: rtl/lsq_pkg.sv
// Shared definitions for the load/store queue: per-entry state and default sizing.
package lsq_pkg;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_PEND   = 2'd1,
    ST_ISSUED = 2'd2,
    ST_DONE   = 2'd3
  } ent_state_e;

  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_AW    = 32;
  localparam int unsigned DEF_DW    = 32;
  localparam int unsigned DEF_CW    = 4;
  localparam int unsigned DEF_ZW    = 4;

endpackage

// File: rtl/lsq_fwd_match.sv
// Finds the youngest valid store whose word address matches a new load.
module lsq_fwd_match
  import lsq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned AW    = DEF_AW
) (
  input  logic [DEPTH-1:0]                      store_vld,
  input  logic [DEPTH-1:0][AW-3:0]              st_waddr,
  input  logic [AW-3:0]                         ld_waddr,
  input  logic [$clog2(DEPTH)-1:0]              tail,
  output logic                                  hit_c,
  output logic [$clog2(DEPTH)-1:0]              idx_c
);

  localparam int unsigned IDW = $clog2(DEPTH);

  logic [IDW-1:0] idx_k;

  // Walk from oldest (distance DEPTH behind tail) to youngest so the last hit wins.
  always_comb begin
    hit_c = 1'b0;
    idx_c = '0;
    idx_k = '0;
    for (int k = int'(DEPTH); k >= 1; k--) begin
      idx_k = tail - IDW'(k);
      if (store_vld[idx_k] && (st_waddr[idx_k] == ld_waddr)) begin
        hit_c = 1'b1;
        idx_c = idx_k;
      end
    end
  end

endmodule

// File: rtl/ldst_queue_fwd.sv
// In-order load/store queue with store-to-load forwarding, in-order issue,
// out-of-order completion and in-order retire.
module ldst_queue_fwd
  import lsq_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned IDW   = $clog2(DEPTH),
  parameter int unsigned AW    = DEF_AW,
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned CW    = DEF_CW,
  parameter int unsigned ZW    = DEF_ZW
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           valid_in_C,
  input  logic           rw_in_C,
  input  logic [AW-1:0]  addr_in_C,
  input  logic [DW-1:0]  data_in_C,
  input  logic [CW-1:0]  cntrl_in_C,
  input  logic [ZW-1:0]  Z_in_C,
  output logic           full_out_C,
  output logic           ready_out_C,
  output logic           rw_out_C,
  output logic [AW-1:0]  addr_out_C,
  output logic [DW-1:0]  data_out_C,
  output logic [CW-1:0]  cntrl_out_C,
  output logic [ZW-1:0]  Z_out_C,
  output logic           valid_out_M,
  output logic           rw_out_M,
  output logic [AW-1:0]  addr_out_M,
  output logic [DW-1:0]  data_out_M,
  output logic [IDW-1:0] ldstID_out_M,
  input  logic           stall_in_M,
  input  logic           ready_in_M,
  input  logic [IDW-1:0] ldstID_in_M,
  input  logic [DW-1:0]  data_in_M,
  output logic           empty
);

  localparam int unsigned CNTW = IDW + 1;

  ent_state_e        st_q    [DEPTH];
  logic [DEPTH-1:0]  rw_q;
  logic [AW-1:0]     addr_q  [DEPTH];
  logic [DW-1:0]     data_q  [DEPTH];
  logic [CW-1:0]     cntrl_q [DEPTH];
  logic [ZW-1:0]     z_q     [DEPTH];

  logic [IDW-1:0]    head_q, iss_q, tail_q;
  logic [CNTW-1:0]   count_q, pend_q, count_nxt;

  logic              retire_c, push_c, fwd_c, iss_vld_c, issue_c, skip_c, adv_c, cpl_c;
  logic              fwd_hit_c;
  logic [IDW-1:0]    fwd_idx_c;
  logic [DEPTH-1:0]          st_vld_c;
  logic [DEPTH-1:0][AW-3:0]  waddr_c;

  always_comb begin
    st_vld_c = '0;
    waddr_c  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      st_vld_c[i] = (st_q[i] != ST_FREE) && rw_q[i];
      waddr_c[i]  = addr_q[i][AW-1:2];
    end
  end

  lsq_fwd_match #(.DEPTH(DEPTH), .AW(AW)) u_fwd_match (
    .store_vld (st_vld_c),
    .st_waddr  (waddr_c),
    .ld_waddr  (addr_in_C[AW-1:2]),
    .tail      (tail_q),
    .hit_c     (fwd_hit_c),
    .idx_c     (fwd_idx_c)
  );

  // A retire frees a slot in the same cycle, so a push is accepted even at full.
  always_comb begin
    full_out_C = (count_q == CNTW'(DEPTH));
    retire_c   = (st_q[head_q] == ST_DONE);
    push_c     = valid_in_C && (!full_out_C || retire_c);
    fwd_c      = push_c && !rw_in_C && fwd_hit_c;
    iss_vld_c  = (pend_q != '0);
    issue_c    = iss_vld_c && (st_q[iss_q] == ST_PEND) && !stall_in_M;
    skip_c     = iss_vld_c && (st_q[iss_q] == ST_DONE);
    adv_c      = issue_c || skip_c;
    cpl_c      = ready_in_M && (st_q[ldstID_in_M] == ST_ISSUED);
    count_nxt  = count_q + CNTW'(push_c) - CNTW'(retire_c);
  end

  // Entry state and pointers; push is last so it wins over a retire of the same slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) st_q[i] <= ST_FREE;
      head_q  <= '0;
      iss_q   <= '0;
      tail_q  <= '0;
      count_q <= '0;
      pend_q  <= '0;
    end else begin
      if (retire_c) st_q[head_q]      <= ST_FREE;
      if (issue_c)  st_q[iss_q]       <= ST_ISSUED;
      if (cpl_c)    st_q[ldstID_in_M] <= ST_DONE;
      if (push_c)   st_q[tail_q]      <= fwd_c ? ST_DONE : ST_PEND;
      head_q  <= head_q + IDW'(retire_c);
      iss_q   <= iss_q + IDW'(adv_c);
      tail_q  <= tail_q + IDW'(push_c);
      count_q <= count_nxt;
      pend_q  <= pend_q + CNTW'(push_c) - CNTW'(adv_c);
    end
  end

  // Payload storage; validity is carried entirely by st_q.
  always_ff @(posedge clk) begin
    if (push_c) begin
      rw_q[tail_q]    <= rw_in_C;
      addr_q[tail_q]  <= addr_in_C;
      cntrl_q[tail_q] <= cntrl_in_C;
      z_q[tail_q]     <= Z_in_C;
      data_q[tail_q]  <= fwd_c ? data_q[fwd_idx_c] : data_in_C;
    end
    if (cpl_c && !rw_q[ldstID_in_M]) data_q[ldstID_in_M] <= data_in_M;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_out_C  <= 1'b0;
      rw_out_C     <= 1'b0;
      addr_out_C   <= '0;
      data_out_C   <= '0;
      cntrl_out_C  <= '0;
      Z_out_C      <= '0;
      valid_out_M  <= 1'b0;
      rw_out_M     <= 1'b0;
      addr_out_M   <= '0;
      data_out_M   <= '0;
      ldstID_out_M <= '0;
      empty        <= 1'b1;
    end else begin
      ready_out_C <= retire_c;
      if (retire_c) begin
        rw_out_C    <= rw_q[head_q];
        addr_out_C  <= addr_q[head_q];
        data_out_C  <= data_q[head_q];
        cntrl_out_C <= cntrl_q[head_q];
        Z_out_C     <= z_q[head_q];
      end
      valid_out_M <= issue_c;
      if (issue_c) begin
        rw_out_M     <= rw_q[iss_q];
        addr_out_M   <= addr_q[iss_q];
        data_out_M   <= data_q[iss_q];
        ldstID_out_M <= iss_q;
      end
      empty <= (count_nxt == '0);
    end
  end

endmodule
